// File: rtl/uart_tx_frame_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_engine
//
// Configurable UART transmit frame engine. It accepts a parallel word through
// a valid/ready handshake and sends one start/data/parity/stop frame on TX_OUT,
// one bit per CLK cycle. CLK runs at the transmit bit rate.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (5..9)
//
// Ports:
//   CLK         transmit bit clock, rising edge
//   RST         synchronous active-low reset
//   P_DATA      parallel word, sampled on accept
//   Data_Valid  source offers P_DATA this cycle
//   PAR_EN      1 = append a parity bit (sampled on accept)
//   PAR_TYP     0 = even, 1 = odd (sampled on accept)
//   STOP2       1 = two stop bits (sampled on accept)
//   TX_READY    combinational, Data_Valid is accepted this cycle
//   Busy        registered, a frame is on the line
//   TX_OUT      registered serial output, idles high
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line idle (TX_OUT=1), waiting for a word
// START  | start bit (TX_OUT=0)
// DATA   | data bits, LSB first, bit_cnt_q counts 0..DATA_WIDTH-1
// PARITY | parity bit over the latched word
// STOP   | one or two stop bits (TX_OUT=1); last one may accept a new word
// ---------------------------------------------------------------------------
module uart_tx_frame_engine #(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic                  TX_READY,
   output logic                  Busy,
   output logic                  TX_OUT
);

   localparam int unsigned CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         bit_cnt_q;
   logic                  stop_cnt_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  par_en_q;
   logic                  par_typ_q;
   logic                  stop2_q;
   logic                  tx_q;
   logic                  busy_q;

   logic                  last_stop;
   logic                  accept;
   logic                  parity_d;

   // Second stop bit is the one with stop_cnt_q set; single-stop frames
   // finish on the first.
   assign last_stop = ~stop2_q | stop_cnt_q;
   assign TX_READY  = (state_q == IDLE) | ((state_q == STOP) & last_stop);
   assign accept    = Data_Valid & TX_READY;

   // Even parity is the plain XOR; odd parity is its inverse.
   assign parity_d  = (^data_q) ^ par_typ_q;

   assign TX_OUT    = tx_q;
   assign Busy      = busy_q;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         data_q     <= '0;
         shift_q    <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         stop2_q    <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         // Shadow copy of the word and its framing options; the frame is
         // immune to input changes once it starts.
         if (accept) begin
            data_q    <= P_DATA;
            shift_q   <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            stop2_q   <= STOP2;
         end

         // tx_q and busy_q are loaded with the value belonging to the state
         // being entered, so they line up with state_q after the edge.
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_q <= START;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
               end else begin
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end

            START: begin
               state_q   <= DATA;
               bit_cnt_q <= '0;
               tx_q      <= shift_q[0];
               shift_q   <= shift_q >> 1;
               busy_q    <= 1'b1;
            end

            DATA: begin
               busy_q <= 1'b1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_q <= '0;
                  if (par_en_q) begin
                     state_q <= PARITY;
                     tx_q    <= parity_d;
                  end else begin
                     state_q    <= STOP;
                     stop_cnt_q <= 1'b0;
                     tx_q       <= 1'b1;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + CW'(1);
                  tx_q      <= shift_q[0];
                  shift_q   <= shift_q >> 1;
               end
            end

            PARITY: begin
               state_q    <= STOP;
               stop_cnt_q <= 1'b0;
               tx_q       <= 1'b1;
               busy_q     <= 1'b1;
            end

            STOP: begin
               if (last_stop) begin
                  stop_cnt_q <= 1'b0;
                  if (accept) begin
                     // Back-to-back: next start bit follows with no idle gap.
                     state_q <= START;
                     tx_q    <= 1'b0;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  stop_cnt_q <= 1'b1;
                  tx_q       <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end

            default: begin
               state_q <= IDLE;
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
module tb_uart_tx_frame_engine;

   logic       CLK = 1'b0;
   logic       RST;
   logic [7:0] p_data8;
   logic [4:0] p_data5;
   logic       valid8;
   logic       valid5;
   logic       par_en;
   logic       par_typ;
   logic       stop2;
   logic       rdy8, busy8, tx8;
   logic       rdy5, busy5, tx5;

   int         checks = 0;
   int         errors = 0;
   logic       exp_q[$];

   always #5 CLK = ~CLK;

   uart_tx_frame_engine #(.DATA_WIDTH(8)) dut8 (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (p_data8),
      .Data_Valid (valid8),
      .PAR_EN     (par_en),
      .PAR_TYP    (par_typ),
      .STOP2      (stop2),
      .TX_READY   (rdy8),
      .Busy       (busy8),
      .TX_OUT     (tx8)
   );

   uart_tx_frame_engine #(.DATA_WIDTH(5)) dut5 (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (p_data5),
      .Data_Valid (valid5),
      .PAR_EN     (par_en),
      .PAR_TYP    (par_typ),
      .STOP2      (stop2),
      .TX_READY   (rdy5),
      .Busy       (busy5),
      .TX_OUT     (tx5)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Reference frame: start, data LSB first, optional parity, stop bit(s).
   task automatic push_frame(input logic [8:0] data, input int w,
                             input logic pe, input logic pt, input logic s2);
      logic par;
      par = pt;
      exp_q.push_back(1'b0);
      for (int i = 0; i < w; i++) begin
         exp_q.push_back(data[i]);
         par = par ^ data[i];
      end
      if (pe) exp_q.push_back(par);
      exp_q.push_back(1'b1);
      if (s2) exp_q.push_back(1'b1);
   endtask

   // One isolated frame from IDLE; inputs are scrambled right after accept.
   task automatic run_frame(input string name, input bit w5, input logic [8:0] data,
                            input logic pe, input logic pt, input logic s2);
      int n;
      @(negedge CLK);
      check($sformatf("%s/ready_idle", name), w5 ? rdy5 : rdy8, 1'b1);
      par_en  = pe;
      par_typ = pt;
      stop2   = s2;
      if (w5) begin
         p_data5 = data[4:0];
         valid5  = 1'b1;
      end else begin
         p_data8 = data[7:0];
         valid8  = 1'b1;
      end
      push_frame(data, w5 ? 5 : 8, pe, pt, s2);
      n = exp_q.size();
      @(negedge CLK);
      valid8  = 1'b0;
      valid5  = 1'b0;
      p_data8 = ~p_data8;
      p_data5 = ~p_data5;
      par_en  = ~pe;
      par_typ = ~pt;
      stop2   = ~s2;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s/tx[%0d]", name, i), w5 ? tx5 : tx8, exp_q.pop_front());
         check($sformatf("%s/busy[%0d]", name, i), w5 ? busy5 : busy8, 1'b1);
         check($sformatf("%s/ready[%0d]", name, i), w5 ? rdy5 : rdy8, i == n - 1);
         @(negedge CLK);
      end
      check($sformatf("%s/tx_after", name), w5 ? tx5 : tx8, 1'b1);
      check($sformatf("%s/busy_after", name), w5 ? busy5 : busy8, 1'b0);
   endtask

   initial begin
      RST     = 1'b0;
      p_data8 = 8'hC3;
      p_data5 = 5'h00;
      valid8  = 1'b1;   // valid during reset must not be accepted
      valid5  = 1'b0;
      par_en  = 1'b0;
      par_typ = 1'b0;
      stop2   = 1'b0;

      repeat (2) @(negedge CLK);
      check("reset/tx8", tx8, 1'b1);
      check("reset/busy8", busy8, 1'b0);
      check("reset/tx5", tx5, 1'b1);
      check("reset/busy5", busy5, 1'b0);
      RST    = 1'b1;
      valid8 = 1'b0;
      @(negedge CLK);
      check("post_reset/ready8", rdy8, 1'b1);
      check("post_reset/ready5", rdy5, 1'b1);
      check("post_reset/busy8", busy8, 1'b0);
      check("post_reset/tx8", tx8, 1'b1);

      run_frame("even_a5", 1'b0, 9'h0A5, 1'b1, 1'b0, 1'b0);
      run_frame("odd_01", 1'b0, 9'h001, 1'b1, 1'b1, 1'b0);
      run_frame("odd_00", 1'b0, 9'h000, 1'b1, 1'b1, 1'b0);
      run_frame("nopar_ff_stop2", 1'b0, 9'h0FF, 1'b0, 1'b0, 1'b1);

      // Back-to-back: Data_Valid held across the first frame's last stop bit.
      @(negedge CLK);
      par_en  = 1'b0;
      par_typ = 1'b0;
      stop2   = 1'b0;
      p_data8 = 8'h55;
      valid8  = 1'b1;
      push_frame(9'h055, 8, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      p_data8 = 8'h0F;
      push_frame(9'h00F, 8, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         check($sformatf("b2b/tx[%0d]", i), tx8, exp_q.pop_front());
         check($sformatf("b2b/busy[%0d]", i), busy8, 1'b1);
         check($sformatf("b2b/ready[%0d]", i), rdy8, (i == 9) || (i == 19));
         if (i == 10) valid8 = 1'b0;
         @(negedge CLK);
      end
      check("b2b/tx_after", tx8, 1'b1);
      check("b2b/busy_after", busy8, 1'b0);

      // Reset while data bit 3 of 8'hA5 is on the line.
      @(negedge CLK);
      p_data8 = 8'hA5;
      par_en  = 1'b1;
      par_typ = 1'b0;
      stop2   = 1'b0;
      valid8  = 1'b1;
      @(negedge CLK);
      valid8 = 1'b0;
      check("rst_mid/start", tx8, 1'b0);
      repeat (4) @(negedge CLK);
      check("rst_mid/bit3", tx8, 1'b0);
      check("rst_mid/busy_bit3", busy8, 1'b1);
      RST = 1'b0;
      @(negedge CLK);
      check("rst_mid/tx", tx8, 1'b1);
      check("rst_mid/busy", busy8, 1'b0);
      RST = 1'b1;
      run_frame("after_rst_3c", 1'b0, 9'h03C, 1'b1, 1'b1, 1'b1);

      run_frame("w5_even_16", 1'b1, 9'h016, 1'b1, 1'b0, 1'b0);
      run_frame("w5_odd_1f_stop2", 1'b1, 9'h01F, 1'b1, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
